// File: rtl/twpm_pkg.sv
// Shared types and constants for the TPM command/response RAM arbiter.
package twpm_pkg;

  localparam int TPM_RAM_AW = 11;

  localparam logic OWNER_DP  = 1'b0;
  localparam logic OWNER_CPU = 1'b1;

  localparam logic [31:0] TPM_DEFAULT_READ_VALUE = 32'hBADFABAC;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SWITCH,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } arb_state_e;

endpackage

// File: rtl/tpm_ram_lane_steer.sv
// Byte-lane steering between the 32-bit RAM word and the two requesters:
// write-enable and write-data formation for the owner, byte select on read.
module tpm_ram_lane_steer (
  input  logic        owner_cpu_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  input  logic        dp_we_i,
  input  logic [1:0]  dp_lane_i,
  input  logic [7:0]  dp_wbyte_i,
  input  logic [1:0]  rd_lane_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wen_o,
  output logic [31:0] wdata_o,
  output logic [7:0]  rd_byte_o
);

  always_comb begin
    wen_o   = 4'b0000;
    wdata_o = wb_dat_i;
    if (owner_cpu_i) begin
      wen_o   = wb_we_i ? wb_sel_i : 4'b0000;
      wdata_o = wb_dat_i;
    end else begin
      // DP writes one byte; replicate it so any lane enable picks it up
      wen_o   = dp_we_i ? (4'b0001 << dp_lane_i) : 4'b0000;
      wdata_o = {4{dp_wbyte_i}};
    end
  end

  always_comb begin
    rd_byte_o = rdata_i[{rd_lane_i, 3'b000} +: 8];
  end

endmodule

// File: rtl/tpm_ram_arbiter.sv
// Single-clock arbiter for the TPM command/response RAM; ownership follows
// exec_i and all RAM/requester outputs are registered one cycle behind state.
module tpm_ram_arbiter
  import twpm_pkg::*;
#(
  parameter int          ADDR_WIDTH         = TPM_RAM_AW,
  parameter logic [31:0] DEFAULT_READ_VALUE = TPM_DEFAULT_READ_VALUE
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  exec_i,
  output logic                  owner_o,
  input  logic                  dp_req_i,
  input  logic                  dp_we_i,
  input  logic [ADDR_WIDTH-1:0] dp_addr_i,
  input  logic [7:0]            dp_data_i,
  output logic [7:0]            dp_data_o,
  output logic                  dp_ack_o,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [3:0]            wb_sel_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [31:0]           wb_dat_i,
  output logic [31:0]           wb_dat_o,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-3:0] ram_addr_o,
  output logic [3:0]            ram_wen_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i,
  output logic [7:0]            deny_cnt_o
);

  arb_state_e state_q, state_d;
  logic       owner_q, owner_d;
  logic       deny_q, deny_d;

  logic                  ram_en_q, ram_en_d;
  logic [ADDR_WIDTH-3:0] ram_addr_q, ram_addr_d;
  logic [3:0]            ram_wen_q, ram_wen_d;
  logic [31:0]           ram_wdata_q, ram_wdata_d;
  logic [1:0]            lane_q, lane_d;
  logic [31:0]           wb_dat_q, wb_dat_d;
  logic [7:0]            dp_data_q, dp_data_d;
  logic                  wb_ack_q, wb_ack_d;
  logic                  wb_err_q, wb_err_d;
  logic                  dp_ack_q, dp_ack_d;
  logic [7:0]            deny_cnt_q, deny_cnt_d;

  logic       wb_req, own_req, resp_busy;
  logic [3:0] steer_wen;
  logic [31:0] steer_wdata;
  logic [7:0] steer_rbyte;
  logic       wb_adr_lo_unused;

  assign wb_adr_lo_unused = ^wb_adr_i[1:0];

  assign wb_req    = wb_cyc_i & wb_stb_i;
  assign own_req   = (owner_q == OWNER_CPU) ? wb_req : dp_req_i;
  // The response pulse is still visible in the first IDLE cycle; holding off
  // here gives the requester that cycle to drop its request.
  assign resp_busy = wb_ack_q | wb_err_q | dp_ack_q;

  tpm_ram_lane_steer u_steer (
    .owner_cpu_i (owner_q == OWNER_CPU),
    .wb_we_i     (wb_we_i),
    .wb_sel_i    (wb_sel_i),
    .wb_dat_i    (wb_dat_i),
    .dp_we_i     (dp_we_i),
    .dp_lane_i   (dp_addr_i[1:0]),
    .dp_wbyte_i  (dp_data_i),
    .rd_lane_i   (lane_q),
    .rdata_i     (ram_rdata_i),
    .wen_o       (steer_wen),
    .wdata_o     (steer_wdata),
    .rd_byte_o   (steer_rbyte)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    deny_d  = deny_q;
    case (state_q)
      ST_IDLE: begin
        if (exec_i != owner_q) begin
          state_d = ST_SWITCH;
        end else if (!resp_busy) begin
          if (own_req) begin
            state_d = ST_ISSUE;
            deny_d  = 1'b0;
          end else if (owner_q == OWNER_DP && wb_req) begin
            state_d = ST_DONE;
            deny_d  = 1'b1;
          end
        end
      end
      ST_SWITCH: begin
        owner_d = exec_i;
        state_d = ST_IDLE;
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT:  state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output stage: registered from state_q, so the RAM strobe lands one edge
  // after ISSUE and read data (1-cycle RAM) is captured together with the ack.
  always_comb begin
    ram_en_d    = 1'b0;
    ram_wen_d   = 4'b0000;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    lane_d      = lane_q;
    wb_dat_d    = wb_dat_q;
    dp_data_d   = dp_data_q;
    wb_ack_d    = 1'b0;
    wb_err_d    = 1'b0;
    dp_ack_d    = 1'b0;
    deny_cnt_d  = deny_cnt_q;
    if (state_q == ST_ISSUE) begin
      ram_en_d    = 1'b1;
      ram_addr_d  = (owner_q == OWNER_CPU) ? wb_adr_i[ADDR_WIDTH-1:2]
                                           : dp_addr_i[ADDR_WIDTH-1:2];
      ram_wen_d   = steer_wen;
      ram_wdata_d = steer_wdata;
      lane_d      = dp_addr_i[1:0];
    end
    if (state_q == ST_DONE) begin
      if (deny_q) begin
        wb_err_d   = 1'b1;
        wb_dat_d   = DEFAULT_READ_VALUE;
        deny_cnt_d = (deny_cnt_q == 8'hFF) ? deny_cnt_q : deny_cnt_q + 8'd1;
      end else if (owner_q == OWNER_CPU) begin
        wb_ack_d = 1'b1;
        wb_dat_d = ram_rdata_i;
      end else begin
        dp_ack_d  = 1'b1;
        dp_data_d = steer_rbyte;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWNER_DP;
      deny_q      <= 1'b0;
      ram_en_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wen_q   <= 4'b0000;
      ram_wdata_q <= '0;
      lane_q      <= 2'd0;
      wb_dat_q    <= '0;
      dp_data_q   <= '0;
      wb_ack_q    <= 1'b0;
      wb_err_q    <= 1'b0;
      dp_ack_q    <= 1'b0;
      deny_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      deny_q      <= deny_d;
      ram_en_q    <= ram_en_d;
      ram_addr_q  <= ram_addr_d;
      ram_wen_q   <= ram_wen_d;
      ram_wdata_q <= ram_wdata_d;
      lane_q      <= lane_d;
      wb_dat_q    <= wb_dat_d;
      dp_data_q   <= dp_data_d;
      wb_ack_q    <= wb_ack_d;
      wb_err_q    <= wb_err_d;
      dp_ack_q    <= dp_ack_d;
      deny_cnt_q  <= deny_cnt_d;
    end
  end

  assign owner_o     = owner_q;
  assign ram_en_o    = ram_en_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wen_o   = ram_wen_q;
  assign ram_wdata_o = ram_wdata_q;
  assign wb_dat_o    = wb_dat_q;
  assign dp_data_o   = dp_data_q;
  assign wb_ack_o    = wb_ack_q;
  assign wb_err_o    = wb_err_q;
  assign dp_ack_o    = dp_ack_q;
  assign deny_cnt_o  = deny_cnt_q;

endmodule

// File: tb/tb_tpm_ram_arbiter.sv
// Directed bench for tpm_ram_arbiter with a behavioural 512x32 synchronous RAM.
module tb_tpm_ram_arbiter;

  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          exec = 1'b0;
  logic          owner;
  logic          dp_req = 1'b0, dp_we = 1'b0;
  logic [AW-1:0] dp_addr = '0;
  logic [7:0]    dp_wdat = '0, dp_rdat;
  logic          dp_ack;
  logic          wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [3:0]    wb_sel = '0;
  logic [AW-1:0] wb_adr = '0;
  logic [31:0]   wb_wdat = '0, wb_rdat;
  logic          wb_ack, wb_err;
  logic          ram_en;
  logic [AW-3:0] ram_addr;
  logic [3:0]    ram_wen;
  logic [31:0]   ram_wdata, ram_rdata;
  logic [7:0]    deny_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tpm_ram_arbiter dut (
    .clk_i(clk), .rst_i(rst), .exec_i(exec), .owner_o(owner),
    .dp_req_i(dp_req), .dp_we_i(dp_we), .dp_addr_i(dp_addr),
    .dp_data_i(dp_wdat), .dp_data_o(dp_rdat), .dp_ack_o(dp_ack),
    .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb), .wb_we_i(wb_we), .wb_sel_i(wb_sel),
    .wb_adr_i(wb_adr), .wb_dat_i(wb_wdat), .wb_dat_o(wb_rdat),
    .wb_ack_o(wb_ack), .wb_err_o(wb_err),
    .ram_en_o(ram_en), .ram_addr_o(ram_addr), .ram_wen_o(ram_wen),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata), .deny_cnt_o(deny_cnt)
  );

  logic [31:0] mem [512];
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;
    ram_rdata = '0;
  end
  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_wen[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      ram_rdata <= mem[ram_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // lat counts edges from the one that samples the request (lat=1).
  task automatic dp_xfer(input logic we, input logic [AW-1:0] a, input logic [7:0] d,
                         output int lat, output logic [7:0] rd, output logic [3:0] wen_seen);
    dp_req = 1'b1; dp_we = we; dp_addr = a; dp_wdat = d;
    lat = -1; rd = '0; wen_seen = '0;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      tick();
      if (ram_en) wen_seen |= ram_wen;
      if (dp_ack) begin lat = c; rd = dp_rdat; end
    end
    dp_req = 1'b0; dp_we = 1'b0;
    tick();
  endtask

  task automatic wb_xfer(input logic we, input logic [AW-1:0] a, input logic [3:0] sel,
                         input logic [31:0] d, output int lat, output logic [31:0] rd,
                         output logic err, output logic [3:0] wen_seen, output logic en_seen);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = a; wb_sel = sel; wb_wdat = d;
    lat = -1; rd = '0; err = 1'b0; wen_seen = '0; en_seen = 1'b0;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      tick();
      en_seen |= ram_en;
      if (ram_en) wen_seen |= ram_wen;
      if (wb_ack || wb_err) begin lat = c; rd = wb_rdat; err = wb_err; end
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    tick();
  endtask

  task automatic do_switch(input logic to);
    exec = to;
    tick();
    chk("switch_wen_dead", {28'd0, ram_wen}, 32'd0);
    tick();
    chk("switch_owner", {31'd0, owner}, {31'd0, to});
  endtask

  int          lat, cnt;
  logic [7:0]  rb;
  logic [31:0] rw;
  logic [3:0]  wen_s;
  logic        err, en_s, own_at_ack;

  initial begin
    // reset state
    repeat (3) tick();
    chk("rst_owner", {31'd0, owner}, 32'd0);
    chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
    chk("rst_ram_wen", {28'd0, ram_wen}, 32'd0);
    chk("rst_acks", {29'd0, wb_ack, wb_err, dp_ack}, 32'd0);
    chk("rst_deny", {24'd0, deny_cnt}, 32'd0);
    chk("rst_wb_dat", wb_rdat, 32'd0);
    chk("rst_ram_addr_wdata", {23'd0, ram_addr} | ram_wdata | {24'd0, dp_rdat}, 32'd0);
    rst = 1'b0;
    tick();

    // DP byte write then read back
    dp_xfer(1'b1, 11'h006, 8'h5A, lat, rb, wen_s);
    chk("dp_wr_lat", lat, 4);
    chk("dp_wr_wen", {28'd0, wen_s}, 32'h4);
    chk("dp_wr_mem", mem[1], 32'h005A0000);
    dp_xfer(1'b0, 11'h006, 8'h00, lat, rb, wen_s);
    chk("dp_rd_lat", lat, 4);
    chk("dp_rd_data", {24'd0, rb}, 32'h5A);
    chk("dp_rd_wen", {28'd0, wen_s}, 32'd0);

    // hand over to CPU, WB accesses
    do_switch(1'b1);
    wb_xfer(1'b0, 11'h004, 4'hF, 32'd0, lat, rw, err, wen_s, en_s);
    chk("wb_rd_lat", lat, 4);
    chk("wb_rd_data", rw, 32'h005A0000);
    chk("wb_rd_err", {31'd0, err}, 32'd0);
    wb_xfer(1'b1, 11'h008, 4'hF, 32'h11223344, lat, rw, err, wen_s, en_s);
    chk("wb_wr_lat", lat, 4);
    chk("wb_wr_wen", {28'd0, wen_s}, 32'hF);
    wb_xfer(1'b1, 11'h00B, 4'h0, 32'hFFFFFFFF, lat, rw, err, wen_s, en_s);
    chk("wb_sel0_lat", lat, 4);
    chk("wb_sel0_en", {31'd0, en_s}, 32'd1);
    chk("wb_sel0_wen", {28'd0, wen_s}, 32'd0);
    wb_xfer(1'b0, 11'h008, 4'hF, 32'd0, lat, rw, err, wen_s, en_s);
    chk("wb_sel0_keep", rw, 32'h11223344);
    wb_xfer(1'b1, 11'h008, 4'b1010, 32'hAABBCCDD, lat, rw, err, wen_s, en_s);
    chk("wb_part_wen", {28'd0, wen_s}, 32'hA);
    wb_xfer(1'b0, 11'h009, 4'hF, 32'd0, lat, rw, err, wen_s, en_s);
    chk("wb_part_data", rw, 32'hAA22CC44);

    // DP stalled while CPU owns, completes after hand-back
    dp_req = 1'b1; dp_we = 1'b0; dp_addr = 11'h00A;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (dp_ack) cnt++;
    end
    chk("dp_stall_noack", cnt, 0);
    exec = 1'b0;
    lat = -1; rb = '0;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      tick();
      if (dp_ack) begin lat = c; rb = dp_rdat; end
    end
    dp_req = 1'b0;
    tick();
    chk("dp_handback_lat", lat, 6);
    chk("dp_handback_data", {24'd0, rb}, 32'h22);

    // WB denied while DP owns
    wb_xfer(1'b0, 11'h000, 4'hF, 32'd0, lat, rw, err, wen_s, en_s);
    chk("deny_lat", lat, 2);
    chk("deny_err", {31'd0, err}, 32'd1);
    chk("deny_dat", rw, 32'hBADFABAC);
    chk("deny_no_ram", {31'd0, en_s}, 32'd0);
    chk("deny_cnt1", {24'd0, deny_cnt}, 32'd1);
    for (int i = 0; i < 299; i++)
      wb_xfer(1'b1, 11'h010, 4'hF, 32'h12345678, lat, rw, err, wen_s, en_s);
    chk("deny_cnt_sat", {24'd0, deny_cnt}, 32'hFF);
    chk("deny_no_write", mem[4], 32'd0);

    // exec drops while a WB write is in WAIT
    do_switch(1'b1);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 11'h00C;
    wb_sel = 4'hF; wb_wdat = 32'hCAFEF00D;
    lat = -1; own_at_ack = 1'b0;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      tick();
      if (c == 2) exec = 1'b0;
      if (wb_ack) begin lat = c; own_at_ack = owner; end
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    chk("late_sw_lat", lat, 4);
    chk("late_sw_owner_at_ack", {31'd0, own_at_ack}, 32'd1);
    tick();
    tick();
    chk("late_sw_owner_after", {31'd0, owner}, 32'd0);
    dp_xfer(1'b0, 11'h00C, 8'h00, lat, rb, wen_s);
    chk("late_sw_lane0", {24'd0, rb}, 32'h0D);
    dp_xfer(1'b0, 11'h00F, 8'h00, lat, rb, wen_s);
    chk("late_sw_lane3", {24'd0, rb}, 32'hCA);

    // reset during WAIT abandons the access
    do_switch(1'b1);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 11'h008; wb_sel = 4'hF;
    tick();
    tick();
    rst = 1'b1; exec = 1'b0;
    tick();
    chk("rst_wait_ack", {31'd0, wb_ack}, 32'd0);
    chk("rst_wait_owner", {31'd0, owner}, 32'd0);
    chk("rst_wait_deny", {24'd0, deny_cnt}, 32'd0);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (wb_ack || wb_err || dp_ack) cnt++;
    end
    chk("rst_wait_no_resp", cnt, 0);
    dp_xfer(1'b0, 11'h008, 8'h00, lat, rb, wen_s);
    chk("post_rst_lat", lat, 4);
    chk("post_rst_data", {24'd0, rb}, 32'h44);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
